// File: rtl/mem_arbiter.sv
// Two-core memory arbiter: funnels instruction/data requests from two cores onto one RAM port.
// Data requests outrank fetches; a round-robin bit breaks ties within a class.
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            iREN,
    input  logic [1:0]            dREN,
    input  logic [1:0]            dWEN,
    input  logic [2*WORD_W-1:0]   iaddr,
    input  logic [2*WORD_W-1:0]   daddr,
    input  logic [2*WORD_W-1:0]   dstore,
    output logic [1:0]            iwait,
    output logic [1:0]            dwait,
    output logic [2*WORD_W-1:0]   iload,
    output logic [2*WORD_W-1:0]   dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [WORD_W-1:0]     ramaddr,
    output logic [WORD_W-1:0]     ramstore,
    input  logic [WORD_W-1:0]     ramload,
    input  logic                  ram_ready,
    output logic                  timeout_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t              state, state_nxt;
    logic                rr;
    logic [7:0]          cnt;
    logic                g_core, g_data, g_write;
    logic [WORD_W-1:0]   g_addr, g_store;

    logic [1:0]          d_req;
    logic                arb_valid, arb_data, arb_core, arb_write;
    logic [WORD_W-1:0]   arb_addr, arb_store;
    logic                req_live, abort, timed_out, done, pulse;

    function automatic logic [WORD_W-1:0] pick_word(input logic [2*WORD_W-1:0] v, input logic c);
        return c ? v[2*WORD_W-1:WORD_W] : v[WORD_W-1:0];
    endfunction

    assign d_req = dREN | dWEN;

    always_comb begin
        arb_valid = (|d_req) || (|iREN);
        arb_data  = |d_req;
        if (arb_data)
            arb_core = d_req[rr] ? rr : ~rr;
        else
            arb_core = iREN[rr] ? rr : ~rr;
        // a simultaneous read+write from one core is served as the write
        arb_write = arb_data && dWEN[arb_core];
        arb_addr  = arb_data ? pick_word(daddr, arb_core) : pick_word(iaddr, arb_core);
        arb_store = arb_data ? pick_word(dstore, arb_core) : '0;
    end

    // Writes are committed once granted; reads live only while the core keeps asking.
    assign req_live  = g_write || (g_data ? dREN[g_core] : iREN[g_core]);
    assign abort     = (state == ACCESS) && !req_live;
    assign timed_out = (state == ACCESS) && req_live && (cnt == TMO);
    assign done      = (state == ACCESS) && req_live && !timed_out && ram_ready;
    assign pulse     = done || timed_out;

    always_comb begin
        state_nxt = state;
        iwait     = 2'b11;
        dwait     = 2'b11;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        case (state)
            IDLE: begin
                if (arb_valid)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                ramREN   = !g_write;
                ramWEN   = g_write;
                ramaddr  = g_addr;
                ramstore = g_store;
                if (pulse) begin
                    if (g_data) dwait[g_core] = 1'b0;
                    else        iwait[g_core] = 1'b0;
                end
                if (done && !g_write) begin
                    if (g_data) begin
                        if (g_core) dload[2*WORD_W-1:WORD_W] = ramload;
                        else        dload[WORD_W-1:0]        = ramload;
                    end else begin
                        if (g_core) iload[2*WORD_W-1:WORD_W] = ramload;
                        else        iload[WORD_W-1:0]        = ramload;
                    end
                end
                if (abort || pulse)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            rr          <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            g_core      <= 1'b0;
            g_data      <= 1'b0;
            g_write     <= 1'b0;
            g_addr      <= '0;
            g_store     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (arb_valid) begin
                    g_core  <= arb_core;
                    g_data  <= arb_data;
                    g_write <= arb_write;
                    g_addr  <= arb_addr;
                    g_store <= arb_store;
                    cnt     <= '0;
                end
            end else begin
                // rr only moves on when the favoured core actually got served
                if (pulse && (g_core == rr))
                    rr <= ~rr;
                if (timed_out)
                    timeout_err <= 1'b1;
                else if (!abort && !ram_ready)
                    cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, expected values written out by hand.
module tb_mem_arbiter;

    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           RST;
    logic [1:0]     iREN, dREN, dWEN;
    logic [2*W-1:0] iaddr, daddr, dstore;
    logic [1:0]     iwait, dwait;
    logic [2*W-1:0] iload, dload;
    logic           ramREN, ramWEN;
    logic [W-1:0]   ramaddr, ramstore, ramload;
    logic           ram_ready;
    logic           timeout_err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WORD_W(W), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ram_ready = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        clear_inputs();
        #2 RST = 1'b1;
        #1;
        total++; if (iwait !== 2'b11) begin bad++; $display("FAIL rst_iwait got=%b exp=11", iwait); end
        total++; if (dwait !== 2'b11) begin bad++; $display("FAIL rst_dwait got=%b exp=11", dwait); end
        total++; if ({ramREN, ramWEN} !== 2'b00) begin bad++; $display("FAIL rst_ramen got=%b exp=00", {ramREN, ramWEN}); end
        total++; if (ramaddr !== '0 || ramstore !== '0) begin bad++; $display("FAIL rst_ramaddr got=%h/%h exp=0/0", ramaddr, ramstore); end
        total++; if (iload !== '0 || dload !== '0) begin bad++; $display("FAIL rst_loads got=%h/%h exp=0/0", iload, dload); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_toerr got=%b exp=0", timeout_err); end
        step();
        RST = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h40;
        #1;
        total++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin bad++; $display("FAIL sr_idle got=%b/%b exp=11/0", iwait, ramREN); end
        step();
        total++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40 || iwait !== 2'b11) begin bad++; $display("FAIL sr_acc1 got=%b addr=%h wait=%b exp=10 addr=40 wait=11", {ramREN, ramWEN}, ramaddr, iwait); end
        step();
        iaddr[31:0] = 32'h44;
        #1;
        total++; if (ramaddr !== 32'h40 || iwait !== 2'b11) begin bad++; $display("FAIL sr_acc2 got=addr %h wait %b exp=addr 40 wait 11", ramaddr, iwait); end
        step();
        ram_ready = 1'b1; ramload = 32'hDEADBEEF;
        #1;
        total++; if (iwait !== 2'b10) begin bad++; $display("FAIL sr_done_wait got=%b exp=10", iwait); end
        total++; if (iload !== {32'h0, 32'hDEADBEEF} || ramaddr !== 32'h40) begin bad++; $display("FAIL sr_done_load got=%h addr=%h exp=00000000deadbeef addr=40", iload, ramaddr); end
        step();
        iREN = '0; ram_ready = 1'b0;
        #1;
        total++; if (iwait !== 2'b11 || iload !== '0 || ramREN !== 1'b0) begin bad++; $display("FAIL sr_after got=%b %h %b exp=11 0 0", iwait, iload, ramREN); end
    endtask

    task automatic test_priority();
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h100;
        dWEN = 2'b10; daddr[63:32] = 32'h80; dstore[63:32] = 32'h1234;
        step();
        total++; if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin bad++; $display("FAIL pri_write got=%b %h %h exp=01 80 1234", {ramREN, ramWEN}, ramaddr, ramstore); end
        ram_ready = 1'b1;
        #1;
        total++; if (dwait !== 2'b01 || iwait !== 2'b11 || dload !== '0) begin bad++; $display("FAIL pri_wdone got=d%b i%b %h exp=d01 i11 0", dwait, iwait, dload); end
        step();
        dWEN = '0; ram_ready = 1'b0;
        #1;
        total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin bad++; $display("FAIL pri_dead got=%b%b exp=00", ramREN, ramWEN); end
        step();
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin bad++; $display("FAIL pri_fetch got=%b %h exp=1 100", ramREN, ramaddr); end
        ram_ready = 1'b1; ramload = 32'hCAFE0001;
        #1;
        total++; if (iwait !== 2'b10 || iload !== {32'h0, 32'hCAFE0001}) begin bad++; $display("FAIL pri_fdone got=%b %h exp=10 00000000cafe0001", iwait, iload); end
        step();
        iREN = '0; ram_ready = 1'b0;
    endtask

    task automatic test_fairness();
        logic           exp_core;
        logic [W-1:0]   val;
        logic [2*W-1:0] exp_load;
        do_reset();
        dREN = 2'b11; daddr = {32'h200, 32'h100};
        for (int k = 0; k < 4; k++) begin
            exp_core = k[0];
            val = 32'hA0000000 + 32'(k);
            exp_load = exp_core ? {val, 32'h0} : {32'h0, val};
            step();
            total++; if (ramREN !== 1'b1 || ramaddr !== (exp_core ? 32'h200 : 32'h100) || dwait !== 2'b11) begin bad++; $display("FAIL fair_grant%0d got=%b %h %b exp_core=%0d", k, ramREN, ramaddr, dwait, exp_core); end
            step();
            ram_ready = 1'b1; ramload = val;
            #1;
            total++; if (dwait !== (exp_core ? 2'b01 : 2'b10) || dload !== exp_load) begin bad++; $display("FAIL fair_done%0d got=%b %h exp=%b %h", k, dwait, dload, (exp_core ? 2'b01 : 2'b10), exp_load); end
            step();
            ram_ready = 1'b0;
            #1;
            total++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin bad++; $display("FAIL fair_dead%0d got=%b %b exp=0 11", k, ramREN, dwait); end
        end
        dREN = '0;
        step();
    endtask

    task automatic test_ready_idle();
        do_reset();
        ram_ready = 1'b1; ramload = 32'h1;
        #1;
        total++; if (dwait !== 2'b11 || iwait !== 2'b11 || dload !== '0 || iload !== '0) begin bad++; $display("FAIL rdyidle_now got=%b %b %h %h exp=11 11 0 0", dwait, iwait, dload, iload); end
        step();
        total++; if ({ramREN, ramWEN} !== 2'b00 || dwait !== 2'b11) begin bad++; $display("FAIL rdyidle_next got=%b %b exp=00 11", {ramREN, ramWEN}, dwait); end
        ram_ready = 1'b0;
    endtask

    task automatic test_read_abort();
        do_reset();
        dREN = 2'b10; daddr[63:32] = 32'h300;
        step();
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin bad++; $display("FAIL abort_grant got=%b %h exp=1 300", ramREN, ramaddr); end
        dREN = '0;
        #1;
        total++; if (dwait !== 2'b11) begin bad++; $display("FAIL abort_nopulse got=%b exp=11", dwait); end
        step();
        total++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin bad++; $display("FAIL abort_idle got=%b %b exp=0 11", ramREN, dwait); end
        dREN = 2'b11; daddr = {32'h300, 32'h140};
        step();
        total++; if (ramaddr !== 32'h140) begin bad++; $display("FAIL abort_rr got=%h exp=140", ramaddr); end
        dREN = '0;
        step();
        dWEN = 2'b10; daddr[63:32] = 32'h340; dstore[63:32] = 32'h55;
        step();
        total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL wr_grant got=%b%b exp=01", ramREN, ramWEN); end
        dWEN = '0;
        #1;
        total++; if (ramWEN !== 1'b1 || dwait !== 2'b11) begin bad++; $display("FAIL wr_drop got=%b %b exp=1 11", ramWEN, dwait); end
        step();
        total++; if (ramWEN !== 1'b1 || ramaddr !== 32'h340 || ramstore !== 32'h55) begin bad++; $display("FAIL wr_hold got=%b %h %h exp=1 340 55", ramWEN, ramaddr, ramstore); end
        ram_ready = 1'b1;
        #1;
        total++; if (dwait !== 2'b01) begin bad++; $display("FAIL wr_done got=%b exp=01", dwait); end
        step();
        ram_ready = 1'b0;
        #1;
        total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL wr_idle got=%b exp=0", ramWEN); end
    endtask

    task automatic test_timeout();
        do_reset();
        iREN = 2'b10; iaddr[63:32] = 32'h500; ramload = 32'hFFFFFFFF;
        for (int c = 1; c <= 4; c++) begin
            step();
            total++; if (iwait !== 2'b11 || ramREN !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b %b %b exp=11 1 0", c, iwait, ramREN, timeout_err); end
        end
        step();
        total++; if (iwait !== 2'b01 || iload !== '0) begin bad++; $display("FAIL to_pulse got=%b %h exp=01 0", iwait, iload); end
        step();
        iREN = '0;
        #1;
        total++; if (timeout_err !== 1'b1 || ramREN !== 1'b0 || iwait !== 2'b11) begin bad++; $display("FAIL to_flag got=%b %b %b exp=1 0 11", timeout_err, ramREN, iwait); end
        step();
        step();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
        RST = 1'b1;
        #1;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dREN = 2'b01; daddr[31:0] = 32'h100;
        step();
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0; dREN = '0;
        dREN = 2'b11; daddr = {32'h600, 32'h100};
        step();
        total++; if (ramaddr !== 32'h600) begin bad++; $display("FAIL rm_rr1 got=%h exp=600", ramaddr); end
        step();
        RST = 1'b1;
        #1;
        total++; if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== '0 || ramstore !== '0) begin bad++; $display("FAIL rm_outs got=%b %h %h exp=00 0 0", {ramREN, ramWEN}, ramaddr, ramstore); end
        total++; if (dwait !== 2'b11 || dload !== '0) begin bad++; $display("FAIL rm_wait got=%b %h exp=11 0", dwait, dload); end
        step();
        RST = 1'b0;
        step();
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin bad++; $display("FAIL rm_rearb got=%b %h exp=1 100", ramREN, ramaddr); end
        dREN = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_fairness();
        test_ready_idle();
        test_read_abort();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning address/data width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum RAM wait cycles before abort (1..255).
REQ-003 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports iREN, dREN, dWEN  in  2 each  the per-core (index 0/1) instruction read, data read and data write requests.
REQ-006 SHALL have ports iaddr, daddr  in  2xWORD_W  the per-core request addresses; dstore  in  2xWORD_W  the per-core write data.
REQ-007 SHALL have ports iwait, dwait  out  2 each  the per-core stall; 0 only in the completion cycle.
REQ-008 SHALL have ports iload, dload  out  2xWORD_W  the per-core read data; valid only when the matching wait is 0, otherwise 0.
REQ-009 SHALL have ports ramREN, ramWEN  out  1; ramaddr, ramstore  out  WORD_W  the single shared RAM port.
REQ-010 SHALL have ports ramload  in  WORD_W  and ram_ready  in  1, where ram_ready indicates that the RAM completed the current access this cycle.
REQ-011 SHALL have port timeout_err  out  1  a sticky flag set on a RAM timeout.

Function
REQ-012 SHALL implement FSM states IDLE and ACCESS; ram outputs are driven only in ACCESS, from registered request fields.
REQ-013 In IDLE with any request pending: latch winner (core, type, addr, store data), go ACCESS next edge; no requests -> stay IDLE.
REQ-014 Priority: data requests beat instruction requests, regardless of core.
REQ-015 Within the same class, a single-bit round-robin pointer rr SHALL pick core rr first; rr flips to the other core only after a completed access by core rr.
REQ-016 Same core with dREN and dWEN both high SHALL be treated as a write.
REQ-017 ACCESS: ramREN=1 for reads, ramWEN=1 for writes, never both; ramaddr/ramstore = latched values.
REQ-018 ACCESS with ram_ready=1: combinationally drop the granted wait bit and route ramload to its load port in that same cycle, then return to IDLE next edge.
REQ-019 Minimum latency is 2 cycles (request seen -> wait low); a back-to-back request is re-arbitrated in the following IDLE cycle (one dead cycle).
REQ-020 Read abort: if the granted read request deasserts during ACCESS before ram_ready, return to IDLE next edge; no wait pulse, rr unchanged.
REQ-021 Writes SHALL NOT abort; a write completes even if dWEN drops.
REQ-022 An 8-bit cycle counter SHALL clear on IDLE->ACCESS and increment each ACCESS cycle without ram_ready; on reaching TIMEOUT: set timeout_err, drop the granted wait for one cycle with load=0, go IDLE.
REQ-023 ram_ready in IDLE SHALL be ignored.
REQ-024 Requests changing address while granted SHALL NOT alter latched ramaddr/ramstore.

Reset
REQ-025 RST high SHALL force IDLE, rr=0, counter=0, timeout_err=0, latched fields=0, all wait bits=1, loads=0, ramREN=ramWEN=0, ramaddr=ramstore=0, immediately (asynchronously).
REQ-026 RST during ACCESS SHALL abandon the transaction without a completion pulse; first arbitration happens in the first cycle after RST falls.

Verification
REQ-027 Single read: iREN[0]=1, iaddr[0]=0x40, ram_ready on 3rd ACCESS cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles; iwait[0]=0, iload[0]=0xDEADBEEF in that cycle only.
REQ-028 Class priority: iREN[0]=1 and dWEN[1]=1 with daddr[1]=0x80, dstore[1]=0x1234 together -> core 1 write served first (ramWEN=1, ramstore=0x1234), then core 0 fetch.
REQ-029 Fairness: dREN=2'b11 held continuously, ram_ready every 2nd ACCESS cycle -> completions alternate core0, core1, core0, core1.
REQ-030 Read abort: dREN[1] granted, dropped after 1 ACCESS cycle -> IDLE next edge, dwait[1] never 0, rr unchanged; write variant completes normally.
REQ-031 Timeout: TIMEOUT=4, ram_ready held 0 -> after 4 ACCESS cycles wait pulse with load=0, timeout_err=1 and stays 1 until RST.
REQ-032 Reset mid-access: RST asserted in ACCESS cycle 2 -> outputs at reset values the same cycle; after release, the pending request re-arbitrated from rr=0.
